// File: rtl/alu_issue_arbiter_pkg.sv
// Shared ALU datapath encodings: aluop codes, operand-mux selects, RV32I opcodes
// and the decoded-control bundle carried in the issue slot.
package alu_issue_arbiter_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        MUX1_RS1  = 2'b00,
        MUX1_PC   = 2'b01,
        MUX1_ZERO = 2'b10
    } mux1_e;

    typedef enum logic [1:0] {
        MUX2_RS2   = 2'b00,
        MUX2_SHAMT = 2'b01,
        MUX2_IMM12 = 2'b10,
        MUX2_IMM20 = 2'b11
    } mux2_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic    illegal;
        mux1_e   mux1;
        mux2_e   mux2;
        alu_op_e aluop;
    } dec_t;

    localparam dec_t DEC_RESET = '{illegal: 1'b0, mux1: MUX1_RS1, mux2: MUX2_RS2, aluop: ALU_ADD};

    // Base operation selected by funct3 alone; bit-30 variants are layered on by the caller.
    function automatic alu_op_e funct3_op(input logic [2:0] funct3);
        alu_op_e op;
        case (funct3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct3/bit30 into operand-mux selects, ALU op
// and an illegal flag for opcodes the shared ALU path does not handle.
module alu_op_decode
    import alu_issue_arbiter_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       f7b5_i,
    output dec_t       dec_o
);

    logic is_shift_imm;

    assign is_shift_imm = (funct3_i == 3'b001) || (funct3_i == 3'b101);

    always_comb begin
        dec_o = DEC_RESET;
        case (opcode_i)
            OPC_OP: begin
                if (f7b5_i && funct3_i == 3'b000) begin
                    dec_o.aluop = ALU_SUB;
                end else if (f7b5_i && funct3_i == 3'b101) begin
                    dec_o.aluop = ALU_SRA;
                end else begin
                    dec_o.aluop = funct3_op(funct3_i);
                end
            end
            OPC_OP_IMM: begin
                // Bit 30 only matters for the immediate shifts; ADDI with it set is still ADD.
                if (is_shift_imm) begin
                    dec_o.mux2  = MUX2_SHAMT;
                    dec_o.aluop = (funct3_i == 3'b101 && f7b5_i) ? ALU_SRA : funct3_op(funct3_i);
                end else begin
                    dec_o.mux2  = MUX2_IMM12;
                    dec_o.aluop = funct3_op(funct3_i);
                end
            end
            OPC_LUI: begin
                dec_o.mux1 = MUX1_ZERO;
                dec_o.mux2 = MUX2_IMM20;
            end
            OPC_AUIPC: begin
                dec_o.mux1 = MUX1_PC;
                dec_o.mux2 = MUX2_IMM20;
            end
            default: begin
                dec_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter sharing the ALU operand-mux/ALU path between two issue
// slots, with a registered valid/ready issue stage feeding execute.
module alu_issue_arbiter
    import alu_issue_arbiter_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [6:0]       req0_opcode,
    input  logic [2:0]       req0_funct3,
    input  logic             req0_f7b5,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [6:0]       req1_opcode,
    input  logic [2:0]       req1_funct3,
    input  logic             req1_f7b5,
    input  logic [TAG_W-1:0] req1_tag,

    output logic             issue_valid,
    input  logic             issue_ready,
    output logic             issue_src,
    output logic [1:0]       issue_mux1,
    output logic [1:0]       issue_mux2,
    output logic [3:0]       issue_aluop,
    output logic [TAG_W-1:0] issue_tag,
    output logic             issue_illegal
);

    logic             valid_q, valid_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             src_q, src_d;
    dec_t             dec_q, dec_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic             slot_load;
    logic             grant0, grant1, grant_any;
    logic [6:0]       sel_opcode;
    logic [2:0]       sel_funct3;
    logic             sel_f7b5;
    logic [TAG_W-1:0] sel_tag;
    dec_t             sel_dec;

    // The slot accepts when empty or draining this cycle; nothing is granted during reset.
    assign slot_load = ~valid_q | issue_ready;
    assign grant0    = ~rst & slot_load & req0_valid & (~req1_valid | ~rr_ptr_q);
    assign grant1    = ~rst & slot_load & req1_valid & (~req0_valid |  rr_ptr_q);
    assign grant_any = grant0 | grant1;

    assign sel_opcode = grant1 ? req1_opcode : req0_opcode;
    assign sel_funct3 = grant1 ? req1_funct3 : req0_funct3;
    assign sel_f7b5   = grant1 ? req1_f7b5   : req0_f7b5;
    assign sel_tag    = grant1 ? req1_tag    : req0_tag;

    alu_op_decode u_decode (
        .opcode_i (sel_opcode),
        .funct3_i (sel_funct3),
        .f7b5_i   (sel_f7b5),
        .dec_o    (sel_dec)
    );

    always_comb begin
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
        src_d    = src_q;
        dec_d    = dec_q;
        tag_d    = tag_q;
        if (grant_any) begin
            valid_d  = 1'b1;
            rr_ptr_d = grant0;
            src_d    = grant1;
            dec_d    = sel_dec;
            tag_d    = sel_tag;
        end else if (issue_ready) begin
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
            src_q    <= 1'b0;
            dec_q    <= DEC_RESET;
            tag_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
            src_q    <= src_d;
            dec_q    <= dec_d;
            tag_q    <= tag_d;
        end
    end

    assign req0_ready    = grant0;
    assign req1_ready    = grant1;
    assign issue_valid   = valid_q;
    assign issue_src     = src_q;
    assign issue_mux1    = dec_q.mux1;
    assign issue_mux2    = dec_q.mux2;
    assign issue_aluop   = dec_q.aluop;
    assign issue_tag     = tag_q;
    assign issue_illegal = dec_q.illegal;

    a_grant_onehot: assert property (@(posedge clk) !(grant0 && grant1));
    a_mux1_legal:   assert property (@(posedge clk) disable iff (rst) issue_mux1 != 2'b11);
    a_aluop_legal:  assert property (@(posedge clk) disable iff (rst) issue_aluop <= 4'd9);

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter: a cycle-level reference model checked
// every cycle, plus hand-computed spot checks along the directed sequence.
module tb_alu_issue_arbiter;

    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0_valid = 1'b0, req1_valid = 1'b0;
    logic req0_ready, req1_ready;
    logic [6:0] req0_opcode = '0, req1_opcode = '0;
    logic [2:0] req0_funct3 = '0, req1_funct3 = '0;
    logic req0_f7b5 = 1'b0, req1_f7b5 = 1'b0;
    logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
    logic issue_valid, issue_ready = 1'b0, issue_src, issue_illegal;
    logic [1:0] issue_mux1, issue_mux2;
    logic [3:0] issue_aluop;
    logic [TAG_W-1:0] issue_tag;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_issue_arbiter #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_funct3(req0_funct3), .req0_f7b5(req0_f7b5), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_funct3(req1_funct3), .req1_f7b5(req1_f7b5), .req1_tag(req1_tag),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_src(issue_src),
        .issue_mux1(issue_mux1), .issue_mux2(issue_mux2), .issue_aluop(issue_aluop),
        .issue_tag(issue_tag), .issue_illegal(issue_illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: what the issue slot must contain, derived from the instruction rules.
    logic m_armed = 1'b0;
    logic m_valid = 1'b0, m_rr = 1'b0, m_fields_known = 1'b0;
    logic m_src = 1'b0, m_ill = 1'b0;
    logic [1:0] m_mux1 = '0, m_mux2 = '0;
    logic [3:0] m_aluop = '0;
    logic [TAG_W-1:0] m_tag = '0;

    function automatic void mdec(input logic [6:0] op, input logic [2:0] f3, input logic b5,
                                 output logic ill, output logic [1:0] m1, output logic [1:0] m2,
                                 output logic [3:0] aop);
        int base [8];
        base = '{0, 2, 3, 4, 5, 6, 8, 9};
        ill = 1'b0; m1 = 2'd0; m2 = 2'd0; aop = 4'd0;
        if (op == 7'h33) begin
            aop = 4'(base[f3]);
            if (b5 && f3 == 3'd0) aop = 4'd1;
            if (b5 && f3 == 3'd5) aop = 4'd7;
        end else if (op == 7'h13) begin
            aop = 4'(base[f3]);
            if (f3 == 3'd1 || f3 == 3'd5) begin
                m2 = 2'd1;
                if (f3 == 3'd5 && b5) aop = 4'd7;
            end else begin
                m2 = 2'd2;
            end
        end else if (op == 7'h37) begin
            m1 = 2'd2; m2 = 2'd3;
        end else if (op == 7'h17) begin
            m1 = 2'd1; m2 = 2'd3;
        end else begin
            ill = 1'b1;
        end
    endfunction

    function automatic logic [1:0] mgrant();
        logic can;
        logic g0, g1;
        can = !rst && (!m_valid || issue_ready);
        g0 = can && req0_valid && (!req1_valid || !m_rr);
        g1 = can && req1_valid && (!req0_valid || m_rr);
        return {g1, g0};
    endfunction

    always @(posedge clk) begin
        logic [1:0] g;
        if (rst) begin
            m_armed = 1'b1;
            m_valid = 1'b0; m_rr = 1'b0; m_fields_known = 1'b1;
            m_src = 1'b0; m_ill = 1'b0; m_mux1 = '0; m_mux2 = '0; m_aluop = '0; m_tag = '0;
        end else if (m_armed) begin
            g = mgrant();
            if (g[1]) begin
                mdec(req1_opcode, req1_funct3, req1_f7b5, m_ill, m_mux1, m_mux2, m_aluop);
                m_tag = req1_tag; m_src = 1'b1; m_valid = 1'b1; m_rr = 1'b0; m_fields_known = 1'b1;
            end else if (g[0]) begin
                mdec(req0_opcode, req0_funct3, req0_f7b5, m_ill, m_mux1, m_mux2, m_aluop);
                m_tag = req0_tag; m_src = 1'b0; m_valid = 1'b1; m_rr = 1'b1; m_fields_known = 1'b1;
            end else if (issue_ready && m_valid) begin
                m_valid = 1'b0;
                m_fields_known = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] g;
        if (m_armed) begin
            g = mgrant();
            chk("m_req0_ready", 32'(req0_ready), 32'(g[0]));
            chk("m_req1_ready", 32'(req1_ready), 32'(g[1]));
            chk("m_issue_valid", 32'(issue_valid), 32'(m_valid));
            if (m_fields_known) begin
                chk("m_issue_src", 32'(issue_src), 32'(m_src));
                chk("m_issue_mux1", 32'(issue_mux1), 32'(m_mux1));
                chk("m_issue_mux2", 32'(issue_mux2), 32'(m_mux2));
                chk("m_issue_aluop", 32'(issue_aluop), 32'(m_aluop));
                chk("m_issue_tag", 32'(issue_tag), 32'(m_tag));
                chk("m_issue_illegal", 32'(issue_illegal), 32'(m_ill));
            end
        end
    end

    task automatic set0(input logic v, input logic [6:0] op, input logic [2:0] f3,
                        input logic b5, input logic [TAG_W-1:0] t);
        req0_valid = v; req0_opcode = op; req0_funct3 = f3; req0_f7b5 = b5; req0_tag = t;
    endtask

    task automatic set1(input logic v, input logic [6:0] op, input logic [2:0] f3,
                        input logic b5, input logic [TAG_W-1:0] t);
        req1_valid = v; req1_opcode = op; req1_funct3 = f3; req1_f7b5 = b5; req1_tag = t;
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        set0(1'b1, 7'h33, 3'd0, 1'b0, 4'd1);
        mid(); chk("rst_req0_ready", 32'(req0_ready), 32'd0); fin();
        fin();
        rst = 1'b0;
        idle();
        mid(); chk("post_rst_valid", 32'(issue_valid), 32'd0); fin();

        // Back-to-back from req0: ADD, SRAI, LUI
        issue_ready = 1'b1;
        set0(1'b1, 7'b0110011, 3'b000, 1'b0, 4'd1);
        mid(); chk("b2b_add_ready", 32'(req0_ready), 32'd1); fin();
        set0(1'b1, 7'b0010011, 3'b101, 1'b1, 4'd2);
        mid(); chk("b2b_add_aluop", 32'(issue_aluop), 32'd0); chk("b2b_add_mux2", 32'(issue_mux2), 32'd0); fin();
        set0(1'b1, 7'b0110111, 3'b000, 1'b0, 4'd3);
        mid(); chk("b2b_srai_aluop", 32'(issue_aluop), 32'd7); chk("b2b_srai_mux2", 32'(issue_mux2), 32'd1); fin();
        idle();
        mid(); chk("b2b_lui_mux1", 32'(issue_mux1), 32'd2); chk("b2b_lui_mux2", 32'(issue_mux2), 32'd3);
        chk("b2b_lui_aluop", 32'(issue_aluop), 32'd0); fin();
        mid(); chk("b2b_drained", 32'(issue_valid), 32'd0); fin();

        // Contention: rr_ptr now points at req1
        set0(1'b1, 7'b0110011, 3'b110, 1'b0, 4'd4);
        set1(1'b1, 7'b0010011, 3'b100, 1'b0, 4'd5);
        mid(); chk("cont_first_req1", 32'(req1_ready), 32'd1); fin();
        mid(); chk("cont_src1", 32'(issue_src), 32'd1); chk("cont_g_req0", 32'(req0_ready), 32'd1); fin();
        mid(); chk("cont_src0", 32'(issue_src), 32'd0); chk("cont_g_req1", 32'(req1_ready), 32'd1); fin();
        mid(); chk("cont_src1b", 32'(issue_src), 32'd1); fin();

        // Backpressure with slot holding req0's OR
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("bp_req0_ready", 32'(req0_ready), 32'd0);
            chk("bp_req1_ready", 32'(req1_ready), 32'd0);
            chk("bp_aluop_held", 32'(issue_aluop), 32'd8);
            chk("bp_src_held", 32'(issue_src), 32'd0);
            fin();
        end
        issue_ready = 1'b1;
        mid(); chk("bp_release_req1", 32'(req1_ready), 32'd1); fin();
        idle();
        mid(); chk("bp_reload_src", 32'(issue_src), 32'd1); chk("bp_reload_aluop", 32'(issue_aluop), 32'd5);
        chk("bp_reload_mux2", 32'(issue_mux2), 32'd2); fin();

        // Reset while holding SUB under stall
        set0(1'b1, 7'b0110011, 3'b000, 1'b1, 4'd7);
        fin();
        idle();
        issue_ready = 1'b0;
        mid(); chk("stall_sub_aluop", 32'(issue_aluop), 32'd1); fin();
        rst = 1'b1;
        set0(1'b1, 7'b0110011, 3'b111, 1'b0, 4'd5);
        set1(1'b1, 7'b0110011, 3'b100, 1'b0, 4'd6);
        mid(); chk("rst_mid_req0_ready", 32'(req0_ready), 32'd0); chk("rst_mid_req1_ready", 32'(req1_ready), 32'd0); fin();
        rst = 1'b0;
        mid(); chk("rst_valid", 32'(issue_valid), 32'd0); chk("rst_aluop", 32'(issue_aluop), 32'd0);
        chk("rst_tag", 32'(issue_tag), 32'd0); chk("rst_src", 32'(issue_src), 32'd0);
        chk("rst_mux1", 32'(issue_mux1), 32'd0); chk("rst_mux2", 32'(issue_mux2), 32'd0);
        chk("rst_illegal", 32'(issue_illegal), 32'd0); chk("rst_rr_req0", 32'(req0_ready), 32'd1); fin();
        idle();
        issue_ready = 1'b1;
        mid(); chk("rst_and_src", 32'(issue_src), 32'd0); chk("rst_and_aluop", 32'(issue_aluop), 32'd9);
        chk("rst_and_tag", 32'(issue_tag), 32'd5); fin();

        // AUIPC from req1
        set1(1'b1, 7'b0010111, 3'b000, 1'b0, 4'hA);
        mid(); chk("auipc_ready", 32'(req1_ready), 32'd1); fin();
        idle();
        mid(); chk("auipc_mux1", 32'(issue_mux1), 32'd1); chk("auipc_mux2", 32'(issue_mux2), 32'd3);
        chk("auipc_aluop", 32'(issue_aluop), 32'd0); chk("auipc_tag", 32'(issue_tag), 32'hA);
        chk("auipc_src", 32'(issue_src), 32'd1); fin();

        // Illegal load opcode, then ADDI with bit30 set
        set0(1'b1, 7'b0000011, 3'b010, 1'b0, 4'd3);
        mid(); chk("ill_accepted", 32'(req0_ready), 32'd1); fin();
        set0(1'b1, 7'b0010011, 3'b000, 1'b1, 4'd4);
        mid(); chk("ill_flag", 32'(issue_illegal), 32'd1); chk("ill_mux1", 32'(issue_mux1), 32'd0);
        chk("ill_mux2", 32'(issue_mux2), 32'd0); chk("ill_aluop", 32'(issue_aluop), 32'd0); fin();
        idle();
        mid(); chk("addi_aluop", 32'(issue_aluop), 32'd0); chk("addi_mux2", 32'(issue_mux2), 32'd2);
        chk("addi_illegal", 32'(issue_illegal), 32'd0); fin();

        // Withdrawal before grant leaves rr_ptr alone
        set0(1'b1, 7'b0110011, 3'b100, 1'b0, 4'd6);
        fin();
        idle();
        issue_ready = 1'b0;
        set1(1'b1, 7'b0110011, 3'b010, 1'b0, 4'd8);
        mid(); chk("wd_blocked", 32'(req1_ready), 32'd0); fin();
        fin();
        idle();
        issue_ready = 1'b1;
        fin();
        set0(1'b1, 7'b0110011, 3'b011, 1'b0, 4'd9);
        set1(1'b1, 7'b0110011, 3'b010, 1'b0, 4'd8);
        mid(); chk("wd_rr_req1", 32'(req1_ready), 32'd1); fin();
        idle();
        fin();
        fin();

        // issue_ready while empty has no effect; then sweep funct3/bit30 for OP and OP-IMM
        issue_ready = 1'b1;
        fin();
        for (int k = 0; k < 32; k++) begin
            set0(1'b1, (k < 16) ? 7'b0110011 : 7'b0010011, 3'(k % 8), 1'((k / 8) % 2), 4'(k));
            fin();
        end
        idle();
        fin();
        fin();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Shares the single ALU operand-mux/ALU datapath between two instruction requesters (issue slot 0 and issue slot 1). It arbitrates round-robin and decodes the granted instruction's opcode/funct fields into operand-mux selects and ALU operation. It presents the result through a registered valid/ready output stage that drives the operand mux selects and ALU op for the execute stage.

## Interface
- Parameters
- TAG_W, 4, width of the instruction tag carried through to execute
- Ports
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid / req1_valid  input  1  requester N holds a decoded instruction
- req0_ready / req1_ready  output  1  requester N's instruction accepted this cycle
- reqN_opcode  input  7  RV32I opcode field of requester N
- reqN_funct3  input  3  funct3 of requester N
- reqN_f7b5  input  1  instruction bit 30 of requester N (SUB/SRA select)
- reqN_tag  input  TAG_W  requester N tag
- issue_valid  output  1  registered issue slot holds a granted instruction
- issue_ready  input  1  execute stage consumes issue slot this cycle
- issue_src  output  1  which requester the held instruction came from
- issue_mux1  output  2  aluin1 select: 00 rs1, 01 pc, 10 zero
- issue_mux2  output  2  aluin2 select: 00 rs2, 01 shamt, 10 imm12, 11 imm20
- issue_aluop  output  4  ALU operation code
- issue_tag  output  TAG_W  tag of held instruction
- issue_illegal  output  1  held instruction had an unsupported opcode

## Operation
- Output register ("slot") can load when slot empty or issue_ready=1 (load and drain same cycle allowed, full throughput).
- Arbitration only when slot can load. If one valid requester: grant it. If both valid: grant requester pointed to by rr_ptr. Grant raises reqN_ready combinationally that cycle. No grant when neither is valid.
- rr_ptr: after a grant to N, rr_ptr := ~N. Unchanged when no grant.
- Decode of granted instruction:
  - 0110011 (OP): mux1=00, mux2=00, aluop from funct3, f7b5 (SUB when funct3=000 & f7b5, SRA when funct3=101 & f7b5).
  - 0010011 (OP-IMM): mux1=00; funct3=001/101 -> mux2=01 (shamt), SRA when 101 & f7b5, else SRL/SLL; other funct3 -> mux2=10, f7b5 ignored (ADDI never SUB).
  - 0110111 (LUI): mux1=10, mux2=11, aluop ADD.
  - 0010111 (AUIPC): mux1=01, mux2=11, aluop ADD.
  - Any other opcode: accepted, issue_illegal=1, mux1=00, mux2=00, aluop ADD.
- aluop codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9; 10-15 never emitted. mux1=11 never emitted.
- Slot empties (issue_valid:=0) when issue_ready=1 and no new grant.

## Timing
- Latency: granted instruction appears on issue_* the cycle after reqN_ready=1.
- issue_* fields stable while issue_valid=1 and issue_ready=0.
- issue_ready while issue_valid=0 has no effect.
- Reset (any cycle, including mid-stall): issue_valid=0, issue_src=0, issue_mux1=00, issue_mux2=00, issue_aluop=0, issue_tag=0, issue_illegal=0, rr_ptr=0; reqN_ready=0 during reset cycle. Held instruction is dropped.
- Requesters must hold valid and fields stable until ready; withdrawal before grant is tolerated (no grant, rr_ptr unchanged).

## Structure
- Shared header alu_defs.vh: aluop codes, mux1/mux2 select codes, opcode constants; also used by alu_mux and the ALU.
- One sub-module: alu_op_decode (combinational opcode/funct3/f7b5 -> mux1, mux2, aluop, illegal), one instance on the arbiter-selected fields.
- Top holds rr_ptr, grant logic and the output slot register.

## Test plan
- Reset mid-stall: slot holding SUB, issue_ready=0, assert rst one cycle -> next cycle issue_valid=0, all outputs zero, rr_ptr=0.
- Single requester, back-to-back: req0 sends ADD (0110011/000/0), SRAI (0010011/101/1), LUI with issue_ready=1 -> one per cycle, aluop 0/7/0, mux2 00/01/11, LUI mux1=10.
- Contention: both valid continuously, issue_ready=1 -> grants alternate 0,1,0,1; issue_src follows one cycle later.
- Backpressure: slot full, issue_ready=0 for 3 cycles, both valid -> req0_ready=req1_ready=0 all 3 cycles, issue_* unchanged; release -> drain and reload same cycle.
- AUIPC from req1 -> mux1=01, mux2=11, aluop 0, issue_tag equals req1_tag.
- Illegal opcode 0000011 -> accepted, issue_illegal=1, mux 00/00, aluop 0; ADDI with f7b5=1 -> aluop 0, mux2=10.
